// File: rtl/video_shifter_pkg.sv
// video_pkg: shared widths, colour constants, pixel source enum and the
// pixel-to-colour mapping used by the video shifter.
package video_pkg;

  localparam int WORD_BITS   = 16;
  localparam int COLOUR_BITS = 6;
  localparam int BITCNT_W    = $clog2(WORD_BITS);

  localparam logic [COLOUR_BITS-1:0] COL_WHITE = 6'h3F;
  localparam logic [COLOUR_BITS-1:0] COL_BLACK = 6'h00;

  // Which capture path filled the shift register.
  typedef enum logic {
    NORMAL = 1'b0,
    DEBUG  = 1'b1
  } src_e;

  typedef struct packed {
    logic [COLOUR_BITS-1:0] r;
    logic [COLOUR_BITS-1:0] g;
    logic [COLOUR_BITS-1:0] b;
  } rgb_t;

  // Screen bits are 1 = black. A lit debug pixel is either green-only or white.
  function automatic rgb_t pixel_colour(input logic bit_in, input src_e src,
                                        input logic debug_green);
    rgb_t c;
    c = '{r: COL_BLACK, g: COL_BLACK, b: COL_BLACK};
    if (!bit_in) begin
      if (src == DEBUG && debug_green)
        c.g = COL_WHITE;
      else
        c = '{r: COL_WHITE, g: COL_WHITE, b: COL_WHITE};
    end
    return c;
  endfunction

endpackage

// File: rtl/video_shifter_if.sv
// video_shifter_if: timer-side inputs and VGA-side outputs of the shifter.
//   master : the video timer / RAM side (drives strobes, data, blanks, syncs)
//   slave  : the shifter (drives RGB, aligned syncs, underrun)
interface video_shifter_if;

  logic                           clk8_en;
  logic [video_pkg::WORD_BITS-1:0] ram_data;
  logic [video_pkg::WORD_BITS-1:0] debug_data;
  logic                           load_normal;
  logic                           load_debug;
  logic                           hblank_n;
  logic                           vblank_n;
  logic                           hsync_in;
  logic                           vsync_in;

  logic [video_pkg::COLOUR_BITS-1:0] video_r;
  logic [video_pkg::COLOUR_BITS-1:0] video_g;
  logic [video_pkg::COLOUR_BITS-1:0] video_b;
  logic                             hsync_out;
  logic                             vsync_out;
  logic                             underrun;

  modport master (
    output clk8_en, ram_data, debug_data, load_normal, load_debug,
           hblank_n, vblank_n, hsync_in, vsync_in,
    input  video_r, video_g, video_b, hsync_out, vsync_out, underrun
  );

  modport slave (
    input  clk8_en, ram_data, debug_data, load_normal, load_debug,
           hblank_n, vblank_n, hsync_in, vsync_in,
    output video_r, video_g, video_b, hsync_out, vsync_out, underrun
  );

endinterface

// File: rtl/video_shifter_shift16.sv
// video_shift16: 16-bit pixel shift register with load/shift priority.
// Ports:
//   clk32, reset           pixel clock, async active-high reset
//   clk8_en                load qualifier (one clk32 in four)
//   load_normal/load_debug load strobes; normal wins if both are set
//   ram_data/debug_data    candidate words (1 = black)
//   pix_bit                current pixel (shreg MSB)
//   src                    source of the word now being shifted
//   shift_edge             1 when this edge shifts rather than loads
//   empty                  bit counter has run out (no valid bits left)
module video_shift16
  import video_pkg::*;
(
  input  logic                 clk32,
  input  logic                 reset,
  input  logic                 clk8_en,
  input  logic                 load_normal,
  input  logic                 load_debug,
  input  logic [WORD_BITS-1:0] ram_data,
  input  logic [WORD_BITS-1:0] debug_data,
  output logic                 pix_bit,
  output src_e                 src,
  output logic                 shift_edge,
  output logic                 empty
);

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_BITS - 1);

  logic [WORD_BITS-1:0] shreg;
  logic [BITCNT_W-1:0]  bitcnt;
  logic                 do_load_n;
  logic                 do_load_d;

  always_comb begin
    do_load_n = clk8_en && load_normal;
    do_load_d = clk8_en && load_debug && !load_normal;
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      shreg  <= '1;
      bitcnt <= '0;
      src    <= NORMAL;
    end else if (do_load_n) begin
      shreg  <= ram_data;
      bitcnt <= LAST_BIT;
      src    <= NORMAL;
    end else if (do_load_d) begin
      shreg  <= debug_data;
      bitcnt <= LAST_BIT;
      src    <= DEBUG;
    end else begin
      // Fill with 1 so a starved shifter drains to black.
      shreg  <= {shreg[WORD_BITS-2:0], 1'b1};
      bitcnt <= (bitcnt == '0) ? '0 : bitcnt - 1'b1;
    end
  end

  assign pix_bit    = shreg[WORD_BITS-1];
  assign shift_edge = !(do_load_n || do_load_d);
  assign empty      = (bitcnt == '0);

endmodule

// File: rtl/video_shifter.sv
// video_shifter: serializes timer-loaded screen/debug words to 6-bit RGB,
// aligns blanks and syncs to the pixel stream, and flags a sticky underrun.
// Ports:
//   clk32  pixel clock (only clock)
//   reset  async active-high reset
//   bus    video_shifter_if.slave: timer strobes, data words, blanks/syncs in;
//          video_r/g/b, hsync_out/vsync_out, underrun out
// Parameters:
//   SYNC_NEG    1 = syncs pass through active-low, 0 = both inverted
//   DEBUG_GREEN 1 = debug words render green/black, 0 = white/black
module video_shifter
  import video_pkg::*;
#(
  parameter bit SYNC_NEG    = 1'b1,
  parameter bit DEBUG_GREEN = 1'b1
) (
  input  logic            clk32,
  input  logic            reset,
  video_shifter_if.slave  bus
);

  // Output level of an idle sync after the optional inversion.
  localparam logic SYNC_IDLE = SYNC_NEG ? 1'b1 : 1'b0;

  logic pix_bit;
  src_e src;
  logic shift_edge;
  logic empty;

  video_shift16 u_shift (
    .clk32       (clk32),
    .reset       (reset),
    .clk8_en     (bus.clk8_en),
    .load_normal (bus.load_normal),
    .load_debug  (bus.load_debug),
    .ram_data    (bus.ram_data),
    .debug_data  (bus.debug_data),
    .pix_bit     (pix_bit),
    .src         (src),
    .shift_edge  (shift_edge),
    .empty       (empty)
  );

  // Timing stage: captured with the timer's clk8 outputs, held between strobes.
  logic hb, vb, hs, vs;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      hb <= 1'b0;
      vb <= 1'b0;
      hs <= 1'b1;
      vs <= 1'b1;
    end else if (bus.clk8_en) begin
      hb <= bus.hblank_n;
      vb <= bus.vblank_n;
      hs <= bus.hsync_in;
      vs <= bus.vsync_in;
    end
  end

  // Colour selection. Debug words stay visible in vblank rows so the debug
  // overlay can live below the active screen area.
  logic visible;
  logic debug_row;
  rgb_t rgb_d;

  always_comb begin
    visible   = hb && vb;
    debug_row = hb && !vb && (src == DEBUG);
    rgb_d     = '{r: COL_BLACK, g: COL_BLACK, b: COL_BLACK};
    if (visible || debug_row)
      rgb_d = pixel_colour(pix_bit, src, DEBUG_GREEN);
  end

  // Output stage: one clk32 behind shreg/timing so pixels and syncs line up.
  rgb_t rgb_q;
  logic hsync_q, vsync_q, underrun_q;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      rgb_q   <= '{r: COL_BLACK, g: COL_BLACK, b: COL_BLACK};
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= SYNC_NEG ? hs : ~hs;
      vsync_q <= SYNC_NEG ? vs : ~vs;
    end
  end

  // Underrun: a shift with no bits left during visible video means the timer
  // missed a reload. Blanked periods never count.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset)
      underrun_q <= 1'b0;
    else if (shift_edge && empty && visible)
      underrun_q <= 1'b1;
  end

  assign bus.video_r   = rgb_q.r;
  assign bus.video_g   = rgb_q.g;
  assign bus.video_b   = rgb_q.b;
  assign bus.hsync_out = hsync_q;
  assign bus.vsync_out = vsync_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_video_shifter.sv
// Directed bench for video_shifter. Two instances share stimulus:
//   dut_a: SYNC_NEG=1, DEBUG_GREEN=1   dut_b: SYNC_NEG=0, DEBUG_GREEN=0
module tb_video_shifter;

  localparam logic [17:0] RGB_W = 18'h3FFFF;
  localparam logic [17:0] RGB_K = 18'h00000;
  localparam logic [17:0] RGB_G = 18'h00FC0;

  logic        clk32 = 1'b0;
  logic        reset = 1'b0;
  logic        clk8_en = 1'b0;
  logic        load_normal = 1'b0;
  logic        load_debug = 1'b0;
  logic        hblank_n = 1'b0;
  logic        vblank_n = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [15:0] ram_data = 16'hFFFF;
  logic [15:0] debug_data = 16'hFFFF;

  int ph = 0;
  int n_checks = 0;
  int n_fails = 0;

  video_shifter_if a_if ();
  video_shifter_if b_if ();

  assign a_if.clk8_en = clk8_en;      assign b_if.clk8_en = clk8_en;
  assign a_if.load_normal = load_normal; assign b_if.load_normal = load_normal;
  assign a_if.load_debug = load_debug; assign b_if.load_debug = load_debug;
  assign a_if.hblank_n = hblank_n;    assign b_if.hblank_n = hblank_n;
  assign a_if.vblank_n = vblank_n;    assign b_if.vblank_n = vblank_n;
  assign a_if.hsync_in = hsync_in;    assign b_if.hsync_in = hsync_in;
  assign a_if.vsync_in = vsync_in;    assign b_if.vsync_in = vsync_in;
  assign a_if.ram_data = ram_data;    assign b_if.ram_data = ram_data;
  assign a_if.debug_data = debug_data; assign b_if.debug_data = debug_data;

  video_shifter #(.SYNC_NEG(1'b1), .DEBUG_GREEN(1'b1)) dut_a (
    .clk32 (clk32),
    .reset (reset),
    .bus   (a_if.slave)
  );

  video_shifter #(.SYNC_NEG(1'b0), .DEBUG_GREEN(1'b0)) dut_b (
    .clk32 (clk32),
    .reset (reset),
    .bus   (b_if.slave)
  );

  wire [17:0] rgb_a = {a_if.video_r, a_if.video_g, a_if.video_b};
  wire [17:0] rgb_b = {b_if.video_r, b_if.video_g, b_if.video_b};

  always #5 clk32 = ~clk32;

  // The timer never raises both loads together.
  always @(posedge clk32)
    assert (!(clk8_en && load_normal && load_debug))
      else $error("both load strobes asserted on a clk8 edge");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clk32 cycle; clk8_en follows the bench phase, loads only on phase 0.
  task automatic tick(input logic ln, input logic ld);
    clk8_en     = (ph == 0);
    load_normal = ln;
    load_debug  = ld;
    @(posedge clk32);
    #1;
    ph          = (ph + 1) % 4;
    clk8_en     = 1'b0;
    load_normal = 1'b0;
    load_debug  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(posedge clk32);
    #1;
    reset = 1'b0;
    ph    = 0;
  endtask

  // n ticks with no load; expected pixel from a local model of the word.
  task automatic pix_run(input string tag, input logic [15:0] w, input int n,
                         input logic [17:0] on_a, input logic [17:0] on_b);
    logic [15:0] sh;
    sh = w;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0);
      check($sformatf("%s_a%0d", tag, i), 32'(rgb_a), 32'(sh[15] ? RGB_K : on_a));
      check($sformatf("%s_b%0d", tag, i), 32'(rgb_b), 32'(sh[15] ? RGB_K : on_b));
      sh = {sh[14:0], 1'b1};
    end
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_rgb_a", 32'(rgb_a), 0);
    check("rst_hs_a", 32'(a_if.hsync_out), 1);
    check("rst_vs_a", 32'(a_if.vsync_out), 1);
    check("rst_hs_b", 32'(b_if.hsync_out), 0);
    check("rst_vs_b", 32'(b_if.vsync_out), 0);
    check("rst_ur_a", 32'(a_if.underrun), 0);

    // Alternating pattern, first pixel one clk32 after the load.
    hblank_n = 1'b1; vblank_n = 1'b1; ram_data = 16'hAAAA;
    tick(1'b1, 1'b0);
    check("t1_load_edge", 32'(rgb_a), 0);
    pix_run("t1", 16'hAAAA, 16, RGB_W, RGB_W);

    // Back-to-back words abut with no gap and no underrun.
    do_reset();
    ram_data = 16'h0000;
    tick(1'b1, 1'b0);
    pix_run("t2w0", 16'h0000, 15, RGB_W, RGB_W);
    ram_data = 16'hFFFF;
    tick(1'b1, 1'b0);
    check("t2_bound0", 32'(rgb_a), 32'(RGB_W));
    pix_run("t2w1", 16'hFFFF, 15, RGB_W, RGB_W);
    ram_data = 16'h0000;
    tick(1'b1, 1'b0);
    check("t2_bound1", 32'(rgb_a), 32'(RGB_K));
    check("t2_ur", 32'(a_if.underrun), 0);
    pix_run("t2w2", 16'h0000, 1, RGB_W, RGB_W);

    // Starved shifter: underrun on the shift edge after the last bit.
    do_reset();
    ram_data = 16'h0000;
    tick(1'b1, 1'b0);
    pix_run("t3", 16'h0000, 15, RGB_W, RGB_W);
    check("t3_ur_pre", 32'(a_if.underrun), 0);
    tick(1'b0, 1'b0);
    check("t3_last_bit", 32'(rgb_a), 32'(RGB_W));
    check("t3_ur_set", 32'(a_if.underrun), 1);
    pix_run("t3_tail", 16'hFFFF, 4, RGB_W, RGB_W);
    check("t3_ur_sticky", 32'(a_if.underrun), 1);
    reset = 1'b1;
    #2;
    check("t3_ur_rst", 32'(a_if.underrun), 0);
    @(posedge clk32);
    #1;
    reset = 1'b0;
    ph = 0;

    // Debug word in a vblank row: green on dut_a, white on dut_b, no underrun.
    hblank_n = 1'b1; vblank_n = 1'b0; debug_data = 16'h7FFF;
    tick(1'b0, 1'b1);
    pix_run("t4", 16'h7FFF, 16, RGB_G, RGB_W);
    check("t4_ur", 32'(a_if.underrun), 0);

    // Hblanked normal word stays black; hsync pulse of two clk8 periods.
    do_reset();
    hblank_n = 1'b0; vblank_n = 1'b1; ram_data = 16'h0000; hsync_in = 1'b0;
    tick(1'b1, 1'b0);
    check("t5_hs_a_pre", 32'(a_if.hsync_out), 1);
    check("t5_hs_b_pre", 32'(b_if.hsync_out), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) hsync_in = 1'b1;
      tick(1'b0, 1'b0);
      check($sformatf("t5_rgb%0d", i), 32'(rgb_a), 0);
      check($sformatf("t5_hs_a%0d", i), 32'(a_if.hsync_out), (i < 8) ? 0 : 1);
      check($sformatf("t5_hs_b%0d", i), 32'(b_if.hsync_out), (i < 8) ? 1 : 0);
    end
    check("t5_vs_a", 32'(a_if.vsync_out), 1);
    check("t5_vs_b", 32'(b_if.vsync_out), 0);
    check("t5_ur", 32'(a_if.underrun), 0);

    // Reset mid-word is asynchronous; the next load resumes normally.
    do_reset();
    hblank_n = 1'b1; vblank_n = 1'b1; ram_data = 16'h0000; hsync_in = 1'b0;
    tick(1'b1, 1'b0);
    pix_run("t6pre", 16'h0000, 5, RGB_W, RGB_W);
    check("t6_hs_a_low", 32'(a_if.hsync_out), 0);
    reset = 1'b1;
    #2;
    check("t6_rgb_rst", 32'(rgb_a), 0);
    check("t6_hs_a_rst", 32'(a_if.hsync_out), 1);
    check("t6_hs_b_rst", 32'(b_if.hsync_out), 0);
    check("t6_ur_rst", 32'(a_if.underrun), 0);
    @(posedge clk32);
    #1;
    reset = 1'b0;
    ph = 0;
    hsync_in = 1'b1; ram_data = 16'h00FF;
    tick(1'b1, 1'b0);
    pix_run("t6post", 16'h00FF, 16, RGB_W, RGB_W);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
